// File: rtl/memory_pkg.sv
// memory_pkg: shared types and helpers for sync_memory.
package memory_pkg;

    typedef enum logic {CLEAR, IDLE} state_t;

    localparam int MAX_LANE_WIDTH = 64;

    function automatic int lanes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic int depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Even parity of one lane; narrower lanes are zero-extended by the caller.
    function automatic logic lane_parity(input logic [MAX_LANE_WIDTH-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/memory_rd_pipe.sv
// memory_rd_pipe: LATENCY-stage read data/valid/parity-error pipeline, flushed by rst.
module memory_rd_pipe
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_perr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_perr
);

    logic [LATENCY-1:0]                 v, p;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] d;
    logic [LATENCY:0]                   vs, ps;
    logic [LATENCY:0][DATA_WIDTH-1:0]   ds;

    assign vs = {v, in_valid};
    assign ps = {p, in_valid & in_perr};
    assign ds = {d, in_data};

    // Data stages load only with a valid beat so the output holds the last read.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            p <= '0;
            d <= '0;
        end else begin
            v <= vs[LATENCY-1:0];
            p <= ps[LATENCY-1:0];
            for (int i = 0; i < LATENCY; i++)
                if (vs[i]) d[i] <= ds[i];
        end
    end

    assign out_valid = v[LATENCY-1];
    assign out_data  = d[LATENCY-1];
    assign out_perr  = p[LATENCY-1];

endmodule

// File: rtl/sync_memory.sv
// sync_memory: single-port RAM with byte enables, read latency pipeline and post-reset clear sweep.
// Optional per-lane even parity when MEMORY_PARITY_EN is defined.
module sync_memory
    import memory_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 5,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    BYTE_WIDTH  = 8,
    parameter int                    RD_LATENCY  = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic                             wr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             rd,
`ifdef MEMORY_PARITY_EN
    input  logic                             par_inject,
`endif
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rvalid,
    output logic                             busy,
    output logic                             parity_err
);

    localparam int NB    = lanes(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = depth(ADDR_WIDTH);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("RD_LATENCY must be 1 or 2");
    end

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    sweep, acc_wr, acc_rd, rd_perr;

    assign busy   = state == CLEAR;
    assign sweep  = busy & ~rst;
    assign acc_wr = wr & ~busy & ~rst;
    assign acc_rd = rd & ~busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_n;
            clr_addr <= busy ? clr_addr + 1'b1 : clr_addr;
        end
    end

    always_comb begin
        state_n = (state == CLEAR && &clr_addr) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (sweep)
            mem[clr_addr] <= CLEAR_VALUE;
        else if (acc_wr)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

`ifdef MEMORY_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] clr_par, rd_par;

    always_comb begin
        clr_par = '0;
        rd_par  = '0;
        for (int i = 0; i < NB; i++) begin
            clr_par[i] = lane_parity(MAX_LANE_WIDTH'(CLEAR_VALUE[i*BYTE_WIDTH +: BYTE_WIDTH]));
            rd_par[i]  = lane_parity(MAX_LANE_WIDTH'(mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH]));
        end
    end

    // par_inject flips lane 0's stored parity so the checker can be exercised.
    always_ff @(posedge clk) begin
        if (sweep)
            par[clr_addr] <= clr_par;
        else if (acc_wr)
            for (int i = 0; i < NB; i++)
                if (be[i])
                    par[addr][i] <= lane_parity(MAX_LANE_WIDTH'(wdata[i*BYTE_WIDTH +: BYTE_WIDTH]))
                                    ^ (i == 0 && par_inject);
    end

    assign rd_perr = |(rd_par ^ par[addr]);
`else
    assign rd_perr = 1'b0;
`endif

    memory_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (acc_rd),
        .in_data   (mem[addr]),
        .in_perr   (rd_perr),
        .out_valid (rvalid),
        .out_data  (rdata),
        .out_perr  (parity_err)
    );

endmodule

// File: tb/tb_sync_memory.sv
// tb_sync_memory: directed self-checking bench for sync_memory.
module tb_sync_memory;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  addr = '0;
    logic        wr = 1'b0;
    logic [1:0]  be = '0;
    logic [15:0] wdata = '0;
    logic        rd = 1'b0;
    logic        par_inject = 1'b0;
    logic [15:0] rdata;
    logic        rvalid, busy, parity_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_memory #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (16),
        .BYTE_WIDTH (8),
        .RD_LATENCY (LAT),
        .CLEAR_VALUE(16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr         (wr),
        .be         (be),
        .wdata      (wdata),
        .rd         (rd),
`ifdef MEMORY_PARITY_EN
        .par_inject (par_inject),
`endif
        .rdata      (rdata),
        .rvalid     (rvalid),
        .busy       (busy),
        .parity_err (parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input logic [4:0] a, input logic [1:0] b, input logic [15:0] d);
        @(negedge clk);
        addr = a; be = b; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; par_inject = 1'b0;
    endtask

    task automatic rd_word(input logic [4:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk(tag, 32'(rdata), 32'(exp));
    endtask

    // Counts busy cycles (and any rvalid) from the current negedge, bounded.
    task automatic count_sweep(output int nb, output int nv);
        nb = 0; nv = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            nb++;
            if (rvalid) nv++;
            @(negedge clk);
        end
    endtask

    int nb, nv;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        rst = 1'b0;
        count_sweep(nb, nv);
        chk("sweep1_len", 32'(nb), 32'd32);

        for (int a = 0; a < 32; a++)
            rd_word(5'(a), 16'h0000, $sformatf("clr_%0d", a));

        wr_word(5'h1F, 2'b11, 16'hA55A);
        rd_word(5'h1F, 16'hA55A, "full_1f");

        wr_word(5'h03, 2'b11, 16'h1234);
        wr_word(5'h03, 2'b10, 16'hFF00);
        rd_word(5'h03, 16'hFF34, "lane_hi");
        wr_word(5'h03, 2'b00, 16'h0000);
        rd_word(5'h03, 16'hFF34, "be_zero");
        wr_word(5'h03, 2'b01, 16'hAB56);
        rd_word(5'h03, 16'hFF56, "lane_lo");

        // Back-to-back reads, then rdata must hold after rvalid drops.
        @(negedge clk);
        addr = 5'h03; rd = 1'b1;
        for (int j = 0; j < LAT + 2; j++) begin
            @(posedge clk); #1;
            if (j == 0) addr = 5'h1F;
            if (j == 1) rd = 1'b0;
            chk($sformatf("b2b_rvalid_%0d", j), 32'(rvalid), 32'((j == LAT - 1) || (j == LAT)));
            if (j == LAT - 1) chk("b2b_first", 32'(rdata), 32'h0000FF56);
            if (j >= LAT) chk($sformatf("b2b_second_%0d", j), 32'(rdata), 32'h0000A55A);
        end

        // Same-cycle write and read of one address returns the old word.
        wr_word(5'h07, 2'b11, 16'hBEEF);
        @(negedge clk);
        addr = 5'h07; be = 2'b11; wdata = 16'h0001; wr = 1'b1; rd = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        chk("rfirst_rvalid", 32'(rvalid), 32'd1);
        chk("rfirst_old", 32'(rdata), 32'h0000BEEF);
        rd_word(5'h07, 16'h0001, "rfirst_new");

        // Reset with two reads in flight: nothing may come out.
        @(negedge clk);
        addr = 5'h1F; rd = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("flush_rvalid", 32'(rvalid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wr = 1'b1; be = 2'b11; wdata = 16'hFFFF;
        repeat (10) begin
            @(negedge clk);
            chk("busy_rd_rvalid", 32'(rvalid), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_sweep(nb, nv);
        rd = 1'b0; wr = 1'b0;
        chk("sweep2_len", 32'(nb), 32'd32);
        chk("sweep2_rvalid", 32'(nv), 32'd0);
        chk("sweep2_rvalid_end", 32'(rvalid), 32'd0);
        rd_word(5'h1F, 16'h0000, "reclr_1f");
        rd_word(5'h07, 16'h0000, "reclr_07");
        rd_word(5'h00, 16'h0000, "reclr_00");

`ifdef MEMORY_PARITY_EN
        @(negedge clk);
        par_inject = 1'b1;
        wr_word(5'h0A, 2'b11, 16'h00FF);
        rd_word(5'h0A, 16'h00FF, "par_inj_data");
        chk("par_inj_err", 32'(parity_err), 32'd1);
        wr_word(5'h0A, 2'b11, 16'h00FF);
        rd_word(5'h0A, 16'h00FF, "par_clean_data");
        chk("par_clean_err", 32'(parity_err), 32'd0);
`endif
        chk("perr_idle", 32'(parity_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
